// File: rtl/conv_encoder.sv
// conv_encoder: table-driven convolutional encoder streaming N bits per cycle for L cycles,
// with an optional per-bit error mask XORed onto the output stream.
`default_nettype none

module conv_encoder #(
  parameter int N = 2,
  parameter int K = 1,
  parameter int M = 4,
  parameter int L = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [M-K-1:0]   state_address,
  input  logic [K-1:0]     input_address,
  input  logic [M-K-1:0]   next_state_data,
  input  logic [0:N-1]     output_data,
  input  logic             start,
  input  logic [0:K*L-1]   message,
  input  logic [0:N*L-1]   err_mask,
  output logic             busy,
  output logic [0:N-1]     encoded,
  output logic             valid,
  output logic             last,
  output logic [M-K-1:0]   final_state,
  output logic             state_ok
);

  localparam int S     = M - K;
  localparam int DEPTH = 2 ** (S + K);
  localparam int TW    = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t fsm, fsm_next;

  logic [S-1:0]   ns_tbl  [DEPTH];
  logic [0:N-1]   out_tbl [DEPTH];

  logic [0:K*L-1] msg_reg;
  logic [0:N*L-1] mask_reg;
  logic [S-1:0]   enc_state;
  logic [TW-1:0]  step;

  logic [K-1:0]   sym;
  logic [S+K-1:0] row;
  logic           step_last;
  logic           accept;

  always_comb begin
    sym       = msg_reg[K*int'(step) +: K];
    row       = {enc_state, sym};
    step_last = (step == TW'(L - 1));
    // load has priority: a start coinciding with a table write is dropped
    accept    = (fsm == IDLE) && start && !load;
    fsm_next  = fsm;
    case (fsm)
      IDLE:    if (accept)    fsm_next = RUN;
      RUN:     if (step_last) fsm_next = IDLE;
      default:                fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ns_tbl[i]  <= '0;
        out_tbl[i] <= '0;
      end
      msg_reg     <= '0;
      mask_reg    <= '0;
      enc_state   <= '0;
      step        <= '0;
      busy        <= 1'b0;
      encoded     <= '0;
      valid       <= 1'b0;
      last        <= 1'b0;
      final_state <= '0;
      state_ok    <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          valid <= 1'b0;
          last  <= 1'b0;
          busy  <= accept;
          // The edge after the final slice publishes the end state of that stream
          if (last) begin
            final_state <= enc_state;
            state_ok    <= (enc_state == '0);
          end
          if (load) begin
            ns_tbl[{state_address, input_address}]  <= next_state_data;
            out_tbl[{state_address, input_address}] <= output_data;
          end else if (start) begin
            msg_reg   <= message;
            mask_reg  <= err_mask;
            enc_state <= '0;
            step      <= '0;
          end
        end
        RUN: begin
          encoded   <= out_tbl[row] ^ mask_reg[N*int'(step) +: N];
          valid     <= 1'b1;
          last      <= step_last;
          enc_state <= ns_tbl[row];
          step      <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: scenario tasks for conv_encoder, checked against a table-walking
// reference model and known-answer streams for the rate-1/2 code.
`default_nettype none

module tb_conv_encoder;

  localparam int N  = 2;
  localparam int K  = 1;
  localparam int M  = 4;
  localparam int L  = 7;
  localparam int S  = M - K;
  localparam int NS = 1 << S;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           load = 1'b0;
  logic [S-1:0]   state_address = '0;
  logic [K-1:0]   input_address = '0;
  logic [S-1:0]   next_state_data = '0;
  logic [0:N-1]   output_data = '0;
  logic           start = 1'b0;
  logic [0:K*L-1] message = '0;
  logic [0:N*L-1] err_mask = '0;
  logic           busy;
  logic [0:N-1]   encoded;
  logic           valid;
  logic           last;
  logic [S-1:0]   final_state;
  logic           state_ok;

  always #5 clk = ~clk;

  conv_encoder #(.N(N), .K(K), .M(M), .L(L)) dut (
    .clk(clk), .reset(reset), .load(load),
    .state_address(state_address), .input_address(input_address),
    .next_state_data(next_state_data), .output_data(output_data),
    .start(start), .message(message), .err_mask(err_mask),
    .busy(busy), .encoded(encoded), .valid(valid), .last(last),
    .final_state(final_state), .state_ok(state_ok)
  );

  int checks = 0;
  int errors = 0;

  int         mdl_ns  [NS][2];
  int         mdl_out [NS][2];
  logic [1:0] exp_sl  [L];
  int         exp_final;

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < 2; b++) begin
        mdl_ns[s][b]  = 0;
        mdl_out[s][b] = 0;
      end
  endfunction

  // Walk the tables from state 0, one message bit per step
  function automatic void model_run(input logic [0:L-1] msg, input logic [0:2*L-1] mask);
    int s;
    int b;
    s = 0;
    for (int t = 0; t < L; t++) begin
      b = int'(msg[t]);
      exp_sl[t] = 2'(mdl_out[s][b]) ^ {mask[2*t], mask[2*t+1]};
      s = mdl_ns[s][b];
    end
    exp_final = s;
  endfunction

  task automatic write_tbl(input int s, input int b, input int nsv, input int outv);
    load            = 1'b1;
    state_address   = S'(s);
    input_address   = K'(b);
    next_state_data = S'(nsv);
    output_data     = N'(outv);
    @(negedge clk);
    load = 1'b0;
    mdl_ns[s][b]  = nsv;
    mdl_out[s][b] = outv;
  endtask

  // ns = {b, s0, s1}; out0 = b^s0^s1^s2, out1 = b^s0^s2 (s0 is the state MSB)
  task automatic load_rate_half();
    int o0, o1;
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < 2; b++) begin
        o0 = b ^ ((s >> 2) & 1) ^ ((s >> 1) & 1) ^ (s & 1);
        o1 = b ^ ((s >> 2) & 1) ^ (s & 1);
        write_tbl(s, b, (b << 2) | (s >> 1), (o0 << 1) | o1);
      end
  endtask

  task automatic start_msg(input logic [0:L-1] msg, input logic [0:2*L-1] mask);
    start    = 1'b1;
    message  = msg;
    err_mask = mask;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_gap(input string tag);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_gap: valid=%b busy=%b, want valid=0 busy=1", tag, valid, busy);
    end
  endtask

  task automatic collect(input int nsl, input string tag);
    for (int j = 0; j < nsl; j++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || encoded !== exp_sl[j] || last !== (j == L - 1)) begin
        errors++;
        $display("FAIL %s slice%0d: valid=%b enc=%b last=%b, want valid=1 enc=%b last=%b",
                 tag, j, valid, encoded, last, exp_sl[j], (j == L - 1));
      end
    end
  endtask

  task automatic check_final(input string tag);
    logic ok_exp;
    ok_exp = (exp_final == 0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0 ||
        final_state !== S'(exp_final) || state_ok !== ok_exp) begin
      errors++;
      $display("FAIL %s final: valid=%b busy=%b last=%b fs=%0d ok=%b, want 0 0 0 fs=%0d ok=%b",
               tag, valid, busy, last, final_state, state_ok, exp_final, ok_exp);
    end
  endtask

  task automatic run_one(input logic [0:L-1] msg, input logic [0:2*L-1] mask, input string tag);
    model_run(msg, mask);
    start_msg(msg, mask);
    check_gap(tag);
    collect(L, tag);
    @(negedge clk);
    check_final(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || encoded !== 2'b00 || valid !== 1'b0 || last !== 1'b0 ||
        final_state !== 3'd0 || state_ok !== 1'b1) begin
      errors++;
      $display("FAIL reset: busy=%b enc=%b valid=%b last=%b fs=%0d ok=%b, want 0 00 0 0 0 1",
               busy, encoded, valid, last, final_state, state_ok);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_known_answer();
    load_rate_half();
    exp_sl    = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    exp_final = 0;
    start_msg(7'b1011000, '0);
    check_gap("kat");
    collect(L, "kat");
    @(negedge clk);
    check_final("kat");
  endtask

  task automatic test_error_mask();
    exp_sl    = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
    exp_final = 0;
    start_msg(7'b1011000, 14'b10_0000_0000_0000);
    check_gap("errmask");
    collect(L, "errmask");
    @(negedge clk);
    check_final("errmask");
    run_one(7'($urandom), 14'($urandom), "errmask_rand");
  endtask

  task automatic test_back_to_back();
    model_run(7'b1111111, '0);
    start_msg(7'b1111111, '0);
    check_gap("b2b_a");
    collect(L, "b2b_a");
    model_run(7'b0000000, '0);
    start_msg(7'b0000000, '0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1 || final_state !== 3'b111 || state_ok !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: valid=%b busy=%b fs=%b ok=%b, want 0 1 111 0",
               valid, busy, final_state, state_ok);
    end
    collect(L, "b2b_b");
    @(negedge clk);
    check_final("b2b_b");
  endtask

  task automatic test_load_during_run();
    logic [0:L-1] msg;
    msg = {1'b1, 6'($urandom)};
    model_run(msg, '0);
    start_msg(msg, '0);
    load            = 1'b1;
    state_address   = 3'd0;
    input_address   = 1'b1;
    next_state_data = 3'd4;
    output_data     = 2'b00;
    collect(L, "ldrun_cur");
    load = 1'b0;
    @(negedge clk);
    check_final("ldrun_cur");
    run_one(msg, '0, "ldrun_next");
    write_tbl(0, 1, 4, 0);
    run_one(msg, '0, "ldidle");
    checks++;
    if (exp_sl[0] !== 2'b00) begin
      errors++;
      $display("FAIL ldidle_first: model slice=%b, want 00", exp_sl[0]);
    end
    load_rate_half();
  endtask

  task automatic test_mid_run_reset();
    model_run(7'b1011000, '0);
    start_msg(7'b1011000, '0);
    check_gap("midrst");
    collect(4, "midrst");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || state_ok !== 1'b1 || final_state !== 3'd0) begin
      errors++;
      $display("FAIL midrst_after: valid=%b busy=%b ok=%b fs=%0d, want 0 0 1 0",
               valid, busy, state_ok, final_state);
    end
    model_clear();
    run_one(7'($urandom), 14'($urandom), "midrst_zero");
    load_rate_half();
    test_known_answer();
  endtask

  task automatic test_start_with_load();
    start           = 1'b1;
    message         = 7'($urandom);
    load            = 1'b1;
    state_address   = 3'd3;
    input_address   = 1'b1;
    next_state_data = 3'd5;
    output_data     = 2'b10;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    mdl_ns[3][1]  = 5;
    mdl_out[3][1] = 2;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL startload_c%0d: busy=%b valid=%b, want 0 0", c, busy, valid);
      end
      @(negedge clk);
    end
    run_one(7'b0111000, '0, "startload_tbl");
    load_rate_half();
  endtask

  task automatic test_random();
    logic [0:L-1]   msg;
    logic [0:2*L-1] mask;
    int             fa;
    bit             pending;
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < 2; b++)
        write_tbl(s, b, int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)));
    pending = 1'b0;
    for (int i = 0; i < 12; i++) begin
      msg  = 7'($urandom);
      mask = ($urandom_range(0, 2) == 0) ? 14'($urandom) : '0;
      if (pending && $urandom_range(0, 1) == 1) begin
        fa = exp_final;
        model_run(msg, mask);
        start_msg(msg, mask);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1 || final_state !== S'(fa)) begin
          errors++;
          $display("FAIL rand%0d_gap: valid=%b busy=%b fs=%0d, want 0 1 %0d",
                   i, valid, busy, final_state, fa);
        end
      end else begin
        if (pending) begin
          @(negedge clk);
          check_final("rand");
        end
        model_run(msg, mask);
        start_msg(msg, mask);
        check_gap("rand");
      end
      collect(L, "rand");
      pending = 1'b1;
    end
    @(negedge clk);
    check_final("rand_end");
  endtask

  initial begin
    test_reset();
    test_known_answer();
    test_error_mask();
    test_back_to_back();
    test_load_during_run();
    test_mid_run_reset();
    test_start_with_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
